// File: rtl/motor_pkg.sv
// Shared types and widths for the motor PWM power stage.
package motor_pkg;

  localparam int unsigned PWM_W      = 8;
  localparam int unsigned DEADTIME_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RAMP = 2'b01,
    ST_RUN  = 2'b10,
    ST_STOP = 2'b11
  } motor_state_t;

  // One LSB toward the target, never past it.
  function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt);
    if (cur < tgt) return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/motor_deadtime_gen.sv
// Complementary gate generation with dead time inserted after every raw PWM edge.
module motor_deadtime_gen
  import motor_pkg::*;
#(
  parameter int unsigned DEADTIME = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  input  logic allow,
  output logic hi,
  output logic lo
);

  logic                  raw_q;
  logic [DEADTIME_W-1:0] dt;
  logic [DEADTIME_W-1:0] dt_next;

  always_comb begin
    dt_next = dt;
    if (raw != raw_q) dt_next = DEADTIME_W'(DEADTIME);
    else if (dt != '0) dt_next = dt - 1'b1;
  end

  // Gating on dt_next puts the reload cycle itself inside the dead window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
      dt    <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else if (ena) begin
      raw_q <= raw;
      dt    <= dt_next;
      hi    <= allow & raw & (dt_next == '0);
      lo    <= allow & ~raw & (dt_next == '0);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor power stage: soft-start/stop duty ramp, edge-aligned PWM, dead-time gates, fault latch.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 256,
  parameter int unsigned DEADTIME = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [PWM_W-1:0] speed_cmd,
  input  logic             power_on,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic [PWM_W-1:0] duty_out,
  output logic [1:0]       state_out,
  output logic             at_speed,
  output logic             fault_latched
);

  localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  motor_state_t     state;
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] shadow;
  logic [PWM_W-1:0] cnt;
  logic [PRE_W-1:0] presc;
  logic             flt;
  logic             tick;
  logic             raw;
  logic             allow;
  logic             gate_hi;
  logic             gate_lo;

  assign tick  = (presc == PRE_W'(RAMP_DIV - 1));
  assign raw   = (cnt < shadow);
  assign allow = !fault_in && !flt && (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      duty   <= '0;
      shadow <= '0;
      cnt    <= '0;
      presc  <= '0;
      flt    <= 1'b0;
    end else if (ena) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) shadow <= duty;
      if (fault_in) begin
        flt   <= 1'b1;
        state <= ST_IDLE;
        duty  <= '0;
        presc <= '0;
      end else if (flt) begin
        if (fault_clr) flt <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            duty  <= '0;
            presc <= '0;
            if (power_on) state <= ST_RAMP;
          end
          ST_RAMP: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) duty <= step_toward(duty, speed_cmd);
            if (!power_on) state <= ST_STOP;
            else if (duty == speed_cmd) state <= ST_RUN;
          end
          ST_RUN: begin
            presc <= '0;
            if (!power_on) state <= ST_STOP;
            else if (speed_cmd != duty) state <= ST_RAMP;
          end
          ST_STOP: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) duty <= step_toward(duty, '0);
            if (power_on) state <= ST_RAMP;
            else if (duty == '0) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  motor_deadtime_gen #(
    .DEADTIME(DEADTIME)
  ) u_deadtime (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .raw  (raw),
    .allow(allow),
    .hi   (gate_hi),
    .lo   (gate_lo)
  );

  assign pwm_hi        = gate_hi & ena;
  assign pwm_lo        = gate_lo & ena;
  assign duty_out      = duty;
  assign state_out     = state;
  assign at_speed      = (state == ST_RUN);
  assign fault_latched = flt;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Randomized and directed bench for motor_pwm_driver against a cycle-level reference model.
module tb_motor_pwm_driver;

  localparam int RD = 4;
  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] speed_cmd = '0;
  logic       power_on = 1'b0;
  logic       fault_in = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pwm_hi, pwm_lo, at_speed, fault_latched;
  logic [7:0] duty_out;
  logic [1:0] state_out;

  motor_pwm_driver #(
    .RAMP_DIV(RD),
    .DEADTIME(DT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .speed_cmd    (speed_cmd),
    .power_on     (power_on),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .duty_out     (duty_out),
    .state_out    (state_out),
    .at_speed     (at_speed),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model; states numbered IDLE=0 RAMP=1 RUN=2 STOP=3.
  int m_state, m_duty, m_cnt, m_shadow, m_ticks_in_ramp;
  bit m_flt, m_hi, m_lo;
  bit hist[$];

  function automatic void model_reset();
    m_state = 0; m_duty = 0; m_cnt = 0; m_shadow = 0; m_ticks_in_ramp = 0;
    m_flt = 0; m_hi = 0; m_lo = 0;
    hist.delete();
    for (int i = 0; i <= DT; i++) hist.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit raw, stable, allowed;
    int nxt, target, old_duty;
    raw = (m_cnt < m_shadow);
    hist.push_back(raw);
    void'(hist.pop_front());
    stable = 1;
    foreach (hist[i]) if (hist[i] != raw) stable = 0;
    allowed = !fault_in && !m_flt && (m_state != 0);
    m_hi = allowed && raw && stable;
    m_lo = allowed && !raw && stable;
    old_duty = m_duty;
    if (fault_in) begin
      m_flt = 1; m_state = 0; m_duty = 0; m_ticks_in_ramp = 0;
    end else if (m_flt) begin
      if (fault_clr) m_flt = 0;
    end else begin
      nxt = m_state;
      case (m_state)
        0: nxt = power_on ? 1 : 0;
        1: nxt = !power_on ? 3 : (m_duty == int'(speed_cmd)) ? 2 : 1;
        2: nxt = !power_on ? 3 : (m_duty != int'(speed_cmd)) ? 1 : 2;
        default: nxt = power_on ? 1 : (m_duty == 0) ? 0 : 3;
      endcase
      if (m_state == 1 || m_state == 3) begin
        target = (m_state == 1) ? int'(speed_cmd) : 0;
        m_ticks_in_ramp++;
        if (m_ticks_in_ramp == RD) begin
          m_ticks_in_ramp = 0;
          if (m_duty < target) m_duty++;
          else if (m_duty > target) m_duty--;
        end
      end else begin
        m_ticks_in_ramp = 0;
        if (m_state == 0) m_duty = 0;
      end
      m_state = nxt;
    end
    if (m_cnt == 255) m_shadow = old_duty;
    m_cnt = (m_cnt + 1) % 256;
  endfunction

  task automatic compare_all();
    check("pwm_hi", pwm_hi, m_hi & ena);
    check("pwm_lo", pwm_lo, m_lo & ena);
    check("gates_exclusive", pwm_hi & pwm_lo, 0);
    check("duty_out", duty_out, m_duty);
    check("state_out", state_out, m_state);
    check("at_speed", at_speed, m_state == 2);
    check("fault_latched", fault_latched, m_flt);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && ena) model_step();
    @(negedge clk);
    compare_all();
  endtask

  int n, hi_cnt, lo_cnt, dead_cnt, both_cnt;

  initial begin
    model_reset();
    // Reset held with toggling inputs
    for (int i = 0; i < 8; i++) begin
      speed_cmd = 8'($urandom); power_on = 1'($urandom);
      fault_in = 1'($urandom); fault_clr = 1'($urandom);
      step();
    end
    speed_cmd = 8'h40; power_on = 0; fault_in = 0; fault_clr = 0; ena = 1;
    rst_n = 1;
    step(); step();

    // Soft start to 0x40
    power_on = 1;
    n = 0;
    while (state_out != 2'b01 && n < 10) begin step(); n++; end
    n = 0;
    while (duty_out != 8'h40 && n < 400) begin step(); n++; end
    check("ramp_up_cycles", n, 256);
    n = 0;
    while (state_out != 2'b10 && n < 10) begin step(); n++; end
    check("run_state", state_out, 2'b10);
    check("run_at_speed", at_speed, 1);

    // Steady RUN waveform over one PWM period
    for (int i = 0; i < 600; i++) step();
    hi_cnt = 0; lo_cnt = 0; dead_cnt = 0; both_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (pwm_hi && pwm_lo) both_cnt++;
      else if (pwm_hi) hi_cnt++;
      else if (pwm_lo) lo_cnt++;
      else dead_cnt++;
    end
    check("period_hi", hi_cnt, 60);
    check("period_lo", lo_cnt, 188);
    check("period_dead", dead_cnt, 8);
    check("period_both", both_cnt, 0);

    // Soft stop
    power_on = 0;
    n = 0;
    while (state_out != 2'b11 && n < 10) begin step(); n++; end
    n = 0;
    while (duty_out != 8'h00 && n < 400) begin step(); n++; end
    check("ramp_down_cycles", n, 256);
    step();
    check("stop_to_idle", state_out, 2'b00);

    // Fault mid-ramp
    power_on = 1;
    n = 0;
    while (duty_out != 8'h20 && n < 400) begin step(); n++; end
    check("reached_0x20", duty_out, 8'h20);
    fault_in = 1;
    step();
    check("fault_latch_set", fault_latched, 1);
    check("fault_duty", duty_out, 0);
    check("fault_gates", {pwm_hi, pwm_lo}, 2'b00);
    fault_clr = 1;
    step();
    check("clr_while_fault", fault_latched, 1);
    fault_in = 0; fault_clr = 0;
    step(); step(); step();
    check("latch_holds", fault_latched, 1);
    check("latch_ignores_power", state_out, 2'b00);
    fault_clr = 1;
    step();
    check("fault_cleared", fault_latched, 0);
    check("clear_to_idle", state_out, 2'b00);
    fault_clr = 0;
    step();
    check("restart_ramp", state_out, 2'b01);

    // RUN at 0x40 then retarget down to 0x30
    speed_cmd = 8'h40;
    n = 0;
    while (state_out != 2'b10 && n < 400) begin step(); n++; end
    speed_cmd = 8'h30;
    n = 0;
    while (state_out != 2'b01 && n < 10) begin step(); n++; end
    n = 0;
    while (duty_out != 8'h30 && n < 200) begin step(); n++; end
    check("retarget_cycles", n, 64);
    n = 0;
    while (state_out != 2'b10 && n < 10) begin step(); n++; end
    check("retarget_run", state_out, 2'b10);

    // Randomized operation with a mid-run asynchronous reset
    for (int i = 0; i < 4000; i++) begin
      ena = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 199) == 0) power_on = ~power_on;
      if ($urandom_range(0, 299) == 0) speed_cmd = 8'($urandom);
      fault_in  = ($urandom_range(0, 499) == 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      if (i == 2000) begin
        rst_n = 0;
        model_reset();
        #1;
        check("async_rst_duty", duty_out, 0);
        check("async_rst_gates", {pwm_hi, pwm_lo}, 2'b00);
        check("async_rst_state", state_out, 2'b00);
      end
      if (i == 2003) rst_n = 1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
